csr_commit_tx: RTL and testbench
================================

CSR_COMMIT_TX -- requirements
Module: csr_commit_tx

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the entry-FIFO depth (power of two, at least 2).
REQ-002 The block SHALL have parameter XLEN, default 32, giving the data and pc width.
REQ-003 Ports SHALL be `clock` (in, 1): single clock, rising edge.
REQ-004 Ports SHALL include `reset` (in, 1): asynchronous active-low reset.
REQ-005 Ports SHALL include `wb_valid` (in, 1): writeback presents a commit record.
REQ-006 Ports SHALL include `wb_ready` (out, 1): the block accepts the record this cycle.
REQ-007 Ports SHALL include `wb_csr_wen` (in, 1), `wb_waddr` (in, 12) and `wb_wdata` (in, XLEN): the CSR write part of the record.
REQ-008 Ports SHALL include `wb_exc_wen` (in, 1), `wb_mcause` (in, XLEN) and `wb_pc` (in, XLEN): the exception part of the record and the instruction pc.
REQ-009 Ports SHALL include `out_valid` (out, 1) and `out_ready` (in, 1): handshake towards the DPI commit sink.
REQ-010 Ports SHALL include `out_kind` (out, 1): 0 = CSR write beat, 1 = exception beat.
REQ-011 Ports SHALL include `out_addr` (out, 12), `out_data` (out, XLEN) and `out_pc` (out, XLEN): the beat payload.
REQ-012 Ports SHALL include `out_seq` (out, 8): beat sequence number.

Function
REQ-013 A record SHALL be accepted when wb_valid and wb_ready are both 1.
- wb_ready = ~full.
- wb_ready is computed combinationally from registered state only.
- A pop in the same cycle SHALL NOT raise wb_ready.
REQ-014 An accepted record with wb_csr_wen=0 and wb_exc_wen=0 SHALL be consumed without being stored.
REQ-015 Any other accepted record SHALL be pushed into the FIFO as one entry holding all input fields.
REQ-016 The output FSM SHALL have states IDLE, CSR and EXC.
- IDLE → CSR when the FIFO is non-empty and the head has csr_wen=1.
- IDLE → EXC when the FIFO is non-empty and the head has csr_wen=0.
REQ-017 In CSR state the block SHALL drive out_valid=1, out_kind=0, out_addr=waddr, out_data=wdata, out_pc=pc.
REQ-018 When a CSR beat is accepted (out_valid and out_ready both 1), the FSM SHALL do one of the following:
- go to EXC if the head has exc_wen=1;
- otherwise pop the head and go to CSR/EXC/IDLE according to the next head, with no bubble.
REQ-019 In EXC state the block SHALL drive out_valid=1, out_kind=1, out_addr=12'h342, out_data=mcause, out_pc=pc.
- Acceptance pops the head and selects the next state as in REQ-018.
REQ-020 Once out_valid=1, the payload SHALL stay stable until the beat is accepted.
REQ-021 out_seq SHALL increment by 1 on every accepted beat, wrapping from 8'hFF to 8'h00.
REQ-022 A push and a pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-023 The read and write pointers SHALL be log2(DEPTH)+1 bits, using the extra bit for full/empty detection and wrapping naturally.
REQ-024 Latency from acceptance to out_valid SHALL be 1 cycle when the FIFO was empty.
REQ-025 When out_valid=0, out_kind/out_addr/out_data/out_pc SHALL be 0.

Reset
REQ-026 While reset=0, the block SHALL asynchronously clear the pointers, set the FSM to IDLE, and set out_seq=0, out_valid=0 and all payload outputs to 0.
- wb_ready = 1 after reset.
REQ-027 Reset asserted mid-beat SHALL discard all buffered entries; no beat SHALL be emitted for them.
REQ-028 FIFO storage SHALL NOT require reset.

Structure
REQ-029 A shared package SHALL hold the following:
- localparam CSR_MCAUSE_ADDR = 12'h342;
- the beat-kind constants KIND_CSR=0 and KIND_EXC=1;
- the FSM state enum;
- the entry record typedef.
REQ-030 The FIFO SHALL be a separate sub-module `commit_fifo`, parameterised by DEPTH and entry width; the FSM stays in csr_commit_tx.

Verification
REQ-031 The bench SHALL cover a single CSR record:
- stimulus: csr_wen=1, waddr=12'h300, wdata=32'h1888, pc=32'h8000_0004, out_ready=1;
- response: one beat, kind 0, addr 300, data 1888, seq 0, one cycle after accept.
REQ-032 The bench SHALL cover a dual record:
- stimulus: csr_wen=1, exc_wen=1, waddr=12'h305, wdata=32'h8000_0100, mcause=32'hB, pc=32'h8000_0010;
- response: two consecutive beats, first kind 0 addr 305, then kind 1 addr 342 data B, both with pc 8000_0010.
REQ-033 The bench SHALL cover backpressure:
- stimulus: out_ready=0 while 5 CSR records are offered;
- response: wb_ready drops after 4 are accepted; payload held stable; raising out_ready drains 4 beats in order, seq 0..3.
REQ-034 The bench SHALL cover an empty record:
- stimulus: wb_valid=1 with both wen flags 0;
- response: accepted, no beat emitted, out_seq unchanged.
REQ-035 The bench SHALL cover sequence wrap: 257 CSR beats → out_seq of the final beat is 8'h00.
REQ-036 The bench SHALL cover mid-operation reset:
- stimulus: reset pulled low while 3 entries are buffered and an EXC beat is pending;
- response: out_valid=0 immediately (asynchronous); after release, no stale beats, seq restarts at 0.

Source files
------------

// File: rtl/csr_commit_tx_pkg.sv
// rtl/csr_commit_tx_pkg.sv - shared constants, FSM state and entry record for the CSR commit transmitter
package csr_commit_tx_pkg;

    // CSR address reported with every exception beat (mcause).
    localparam logic [11:0] CSR_MCAUSE_ADDR = 12'h342;

    // Beat kinds on out_kind.
    localparam logic KIND_CSR = 1'b0;
    localparam logic KIND_EXC = 1'b1;

    // Entry data fields are sized for the widest supported XLEN. The top
    // zero-extends on write and truncates on read, so XLEN may be at most this.
    localparam int MAX_XLEN = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CSR  = 2'd1,
        ST_EXC  = 2'd2
    } state_e;

    typedef struct packed {
        logic                csr_wen;
        logic                exc_wen;
        logic [11:0]         waddr;
        logic [MAX_XLEN-1:0] wdata;
        logic [MAX_XLEN-1:0] mcause;
        logic [MAX_XLEN-1:0] pc;
    } commit_entry_t;

    // First beat of a record: CSR write if present, otherwise the exception.
    function automatic state_e first_beat(input logic csr_wen);
        return csr_wen ? ST_CSR : ST_EXC;
    endfunction

endpackage

// File: rtl/commit_fifo.sv
// rtl/commit_fifo.sv - entry FIFO with head and head+1 read ports
//
// Ports:
//   clock, reset      clock and asynchronous active-low reset (pointers only)
//   push, wdata       write an entry
//   pop               drop the head entry
//   head, head_next   entry at the read pointer and the one behind it
//   multi             more than one entry stored
//   full, empty       occupancy flags
module commit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] head_next,
    output logic             multi,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [AW:0]      rptr_inc;
    logic [AW:0]      count;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rptr_inc  = rptr_q + PTR_ONE;
    assign count     = wptr_q - rptr_q;
    assign empty     = (wptr_q == rptr_q);
    // Same slot, different lap: the extra pointer bit tells full from empty.
    assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign multi     = (count > PTR_ONE);
    assign head      = mem_q[rptr_q[AW-1:0]];
    assign head_next = mem_q[rptr_inc[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PTR_ONE;
            if (pop)  rptr_q <= rptr_inc;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/csr_commit_tx.sv
// rtl/csr_commit_tx.sv - buffers writeback commit records and emits CSR / exception beats to the commit sink
//
// Ports:
//   clock, reset                      clock and asynchronous active-low reset
//   wb_valid / wb_ready               writeback record handshake
//   wb_csr_wen, wb_waddr, wb_wdata    CSR write part of the record
//   wb_exc_wen, wb_mcause, wb_pc      exception part and instruction pc
//   out_valid / out_ready             beat handshake to the commit sink
//   out_kind, out_addr, out_data,
//   out_pc, out_seq                   beat payload and sequence number
module csr_commit_tx
    import csr_commit_tx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic            wb_csr_wen,
    input  logic [11:0]     wb_waddr,
    input  logic [XLEN-1:0] wb_wdata,
    input  logic            wb_exc_wen,
    input  logic [XLEN-1:0] wb_mcause,
    input  logic [XLEN-1:0] wb_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_kind,
    output logic [11:0]     out_addr,
    output logic [XLEN-1:0] out_data,
    output logic [XLEN-1:0] out_pc,
    output logic [7:0]      out_seq
);

    commit_entry_t wr_entry;
    commit_entry_t head;
    commit_entry_t head_next;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_multi;
    logic          push;
    logic          pop;
    state_e        state_q;
    state_e        state_d;
    state_e        after_pop;
    logic [7:0]    seq_q;
    logic [7:0]    seq_d;
    logic          unused_bits;

    // Records with neither write flag are accepted and dropped.
    assign wb_ready = ~fifo_full;
    assign push     = wb_valid & wb_ready & (wb_csr_wen | wb_exc_wen);

    always_comb begin
        wr_entry         = '0;
        wr_entry.csr_wen = wb_csr_wen;
        wr_entry.exc_wen = wb_exc_wen;
        wr_entry.waddr   = wb_waddr;
        wr_entry.wdata   = MAX_XLEN'(wb_wdata);
        wr_entry.mcause  = MAX_XLEN'(wb_mcause);
        wr_entry.pc      = MAX_XLEN'(wb_pc);
    end

    commit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(commit_entry_t))
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .wdata     (wr_entry),
        .pop       (pop),
        .head      (head),
        .head_next (head_next),
        .multi     (fifo_multi),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Upper bits of the widened fields and most of head_next are never read.
    assign unused_bits = ^{head, head_next};

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            seq_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
        end
    end

    // Next state. After a pop the next head is the second stored entry, or
    // the record being pushed this very cycle when the FIFO drains to empty,
    // so back-to-back records stream without a bubble.
    always_comb begin
        if (fifo_multi)  after_pop = first_beat(head_next.csr_wen);
        else if (push)   after_pop = first_beat(wb_csr_wen);
        else             after_pop = ST_IDLE;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = first_beat(head.csr_wen);
                else if (push)   state_d = first_beat(wb_csr_wen);
            end
            ST_CSR: begin
                if (out_ready) begin
                    if (head.exc_wen) begin
                        state_d = ST_EXC;
                    end else begin
                        pop     = 1'b1;
                        state_d = after_pop;
                    end
                end
            end
            ST_EXC: begin
                if (out_ready) begin
                    pop     = 1'b1;
                    state_d = after_pop;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: payload comes straight from the head entry, which cannot move
    // until the beat is taken, so it is stable while out_valid is high.
    always_comb begin
        out_valid = 1'b0;
        out_kind  = KIND_CSR;
        out_addr  = '0;
        out_data  = '0;
        out_pc    = '0;
        unique case (state_q)
            ST_CSR: begin
                out_valid = 1'b1;
                out_kind  = KIND_CSR;
                out_addr  = head.waddr;
                out_data  = head.wdata[XLEN-1:0];
                out_pc    = head.pc[XLEN-1:0];
            end
            ST_EXC: begin
                out_valid = 1'b1;
                out_kind  = KIND_EXC;
                out_addr  = CSR_MCAUSE_ADDR;
                out_data  = head.mcause[XLEN-1:0];
                out_pc    = head.pc[XLEN-1:0];
            end
            default: ;
        endcase
    end

    assign seq_d   = (out_valid && out_ready) ? seq_q + 8'd1 : seq_q;
    assign out_seq = seq_q;

endmodule

// File: tb/tb_csr_commit_tx.sv
// tb/tb_csr_commit_tx.sv - self-checking bench for csr_commit_tx
module tb_csr_commit_tx;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            wb_valid = 1'b0;
    logic            wb_ready;
    logic            wb_csr_wen = 1'b0;
    logic [11:0]     wb_waddr = '0;
    logic [XLEN-1:0] wb_wdata = '0;
    logic            wb_exc_wen = 1'b0;
    logic [XLEN-1:0] wb_mcause = '0;
    logic [XLEN-1:0] wb_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_kind;
    logic [11:0]     out_addr;
    logic [XLEN-1:0] out_data;
    logic [XLEN-1:0] out_pc;
    logic [7:0]      out_seq;

    int vec_cnt = 0;
    int err_cnt = 0;

    csr_commit_tx #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock      (clock),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_csr_wen (wb_csr_wen),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata),
        .wb_exc_wen (wb_exc_wen),
        .wb_mcause  (wb_mcause),
        .wb_pc      (wb_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_kind   (out_kind),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_pc     (out_pc),
        .out_seq    (out_seq)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: each accepted record expands into its list of beats.
    typedef struct {
        bit        kind;
        bit [11:0] addr;
        bit [31:0] data;
        bit [31:0] pc;
        bit        last;
    } beat_t;

    beat_t    exp_q[$];
    int       m_entries = 0;
    bit [7:0] m_seq = 8'h00;

    always @(negedge clock) begin
        if (!reset) begin
            exp_q.delete();
            m_entries = 0;
            m_seq     = 8'h00;
        end else begin
            chk("wb_ready", 64'(wb_ready), 64'(m_entries < DEPTH));
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                chk("out_kind", 64'(out_kind), 64'(exp_q[0].kind));
                chk("out_addr", 64'(out_addr), 64'(exp_q[0].addr));
                chk("out_data", 64'(out_data), 64'(exp_q[0].data));
                chk("out_pc",   64'(out_pc),   64'(exp_q[0].pc));
                chk("out_seq",  64'(out_seq),  64'(m_seq));
            end else begin
                chk("idle_payload", 64'({out_kind, out_addr, out_data, out_pc} != 0), 64'(0));
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                if (exp_q[0].last) m_entries--;
                void'(exp_q.pop_front());
                m_seq = m_seq + 8'd1;
            end
            if (wb_valid && wb_ready && (wb_csr_wen || wb_exc_wen)) begin
                if (wb_csr_wen)
                    exp_q.push_back('{1'b0, wb_waddr, wb_wdata, wb_pc, !wb_exc_wen});
                if (wb_exc_wen)
                    exp_q.push_back('{1'b1, 12'h342, wb_mcause, wb_pc, 1'b1});
                m_entries++;
            end
        end
    end

    // All sequencing below runs in the "posedge + 1" phase.
    task automatic send(input logic csr, input logic exc, input logic [11:0] a,
                        input logic [31:0] d, input logic [31:0] mc, input logic [31:0] p);
        int n;
        wb_valid   = 1'b1;
        wb_csr_wen = csr;
        wb_exc_wen = exc;
        wb_waddr   = a;
        wb_wdata   = d;
        wb_mcause  = mc;
        wb_pc      = p;
        n = 0;
        @(negedge clock);
        while (!wb_ready && n < 100) begin
            n++;
            @(negedge clock);
        end
        if (!wb_ready) chk("send_timeout", 64'(0), 64'(1));
        @(posedge clock);
        #1;
        wb_valid   = 1'b0;
        wb_csr_wen = 1'b0;
        wb_exc_wen = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        step();
        step();
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_wb_ready", 64'(wb_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_seq", 64'(out_seq), 64'(0));
        step();

        // Single CSR record
        out_ready = 1'b1;
        send(1'b1, 1'b0, 12'h300, 32'h1888, 32'h0, 32'h8000_0004);
        @(negedge clock);
        chk("t_csr_valid", 64'(out_valid), 64'(1));
        chk("t_csr_kind", 64'(out_kind), 64'(0));
        chk("t_csr_addr", 64'(out_addr), 64'h300);
        chk("t_csr_data", 64'(out_data), 64'h1888);
        chk("t_csr_pc", 64'(out_pc), 64'h8000_0004);
        chk("t_csr_seq", 64'(out_seq), 64'(0));
        step();
        @(negedge clock);
        chk("t_csr_done", 64'(out_valid), 64'(0));
        chk("t_csr_seq1", 64'(out_seq), 64'(1));
        step();

        // Dual record: CSR beat then exception beat, back to back
        send(1'b1, 1'b1, 12'h305, 32'h8000_0100, 32'hB, 32'h8000_0010);
        @(negedge clock);
        chk("t_dual0_kind", 64'(out_kind), 64'(0));
        chk("t_dual0_addr", 64'(out_addr), 64'h305);
        chk("t_dual0_pc", 64'(out_pc), 64'h8000_0010);
        step();
        @(negedge clock);
        chk("t_dual1_valid", 64'(out_valid), 64'(1));
        chk("t_dual1_kind", 64'(out_kind), 64'(1));
        chk("t_dual1_addr", 64'(out_addr), 64'h342);
        chk("t_dual1_data", 64'(out_data), 64'hB);
        chk("t_dual1_pc", 64'(out_pc), 64'h8000_0010);
        step();
        @(negedge clock);
        chk("t_dual_done", 64'(out_valid), 64'(0));
        step();

        // Backpressure: 4 fit, the 5th waits, then drain in order
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(1'b1, 1'b0, 12'h310 + 12'(i), 32'hA0 + 32'(i), 32'h0, 32'h100 + 32'(4 * i));
        wb_valid   = 1'b1;
        wb_csr_wen = 1'b1;
        wb_waddr   = 12'h314;
        wb_wdata   = 32'hA4;
        wb_pc      = 32'h110;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("t_bp_full", 64'(wb_ready), 64'(0));
            chk("t_bp_hold_addr", 64'(out_addr), 64'h310);
            chk("t_bp_hold_data", 64'(out_data), 64'hA0);
        end
        step();
        out_ready = 1'b1;
        fork
            begin
                int n = 0;
                @(negedge clock);
                while (!wb_ready && n < 50) begin
                    n++;
                    @(negedge clock);
                end
                step();
                wb_valid   = 1'b0;
                wb_csr_wen = 1'b0;
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clock);
                    chk("t_bp_drain_addr", 64'(out_addr), 64'(12'h310 + 12'(i)));
                    chk("t_bp_drain_seq", 64'(out_seq), 64'(i));
                end
            end
        join
        step();
        @(negedge clock);
        chk("t_bp_fifth_addr", 64'(out_addr), 64'h314);
        chk("t_bp_fifth_seq", 64'(out_seq), 64'(4));
        repeat (3) step();

        // Empty record: accepted, no beat, seq untouched
        send(1'b0, 1'b0, 12'h123, 32'h55, 32'h66, 32'h77);
        repeat (3) begin
            @(negedge clock);
            chk("t_empty_valid", 64'(out_valid), 64'(0));
            chk("t_empty_seq", 64'(out_seq), 64'(5));
        end
        step();

        // Sequence wrap after 257 beats
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 257; i++)
            send(1'b1, 1'b0, 12'(i), 32'(i), 32'h0, 32'(4 * i));
        @(negedge clock);
        chk("t_wrap_valid", 64'(out_valid), 64'(1));
        chk("t_wrap_addr", 64'(out_addr), 64'h100);
        chk("t_wrap_seq", 64'(out_seq), 64'h00);
        step();

        // Reset in the middle of buffered traffic
        do_reset();
        out_ready = 1'b0;
        send(1'b0, 1'b1, 12'h0, 32'h0, 32'h7, 32'h200);
        send(1'b1, 1'b0, 12'h301, 32'h11, 32'h0, 32'h204);
        send(1'b1, 1'b1, 12'h302, 32'h22, 32'h3, 32'h208);
        @(negedge clock);
        chk("t_mid_exc_pending", 64'(out_kind), 64'(1));
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("t_mid_async_valid", 64'(out_valid), 64'(0));
        chk("t_mid_async_payload", 64'({out_kind, out_addr, out_data, out_pc}), 64'(0));
        chk("t_mid_async_ready", 64'(wb_ready), 64'(1));
        chk("t_mid_async_seq", 64'(out_seq), 64'(0));
        step();
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk("t_mid_no_stale", 64'(out_valid), 64'(0));
        end
        step();
        send(1'b1, 1'b0, 12'h3A0, 32'hCAFE, 32'h0, 32'h300);
        @(negedge clock);
        chk("t_mid_new_addr", 64'(out_addr), 64'h3A0);
        chk("t_mid_new_seq", 64'(out_seq), 64'(0));
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            out_ready  = ($urandom_range(0, 3) != 0);
            wb_valid   = $urandom_range(0, 1);
            wb_csr_wen = $urandom_range(0, 1);
            wb_exc_wen = ($urandom_range(0, 2) == 0);
            wb_waddr   = 12'($urandom);
            wb_wdata   = $urandom;
            wb_mcause  = $urandom;
            wb_pc      = $urandom;
            step();
        end
        wb_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();
        @(negedge clock);
        chk("t_rand_drained", 64'(out_valid), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
